seqswitch_n: RTL and testbench



---
 rtl/seqswitch_pkg.sv | 27 ++
 rtl/seqswitch_n_schmitt.sv | 45 ++++
 rtl/seqswitch_n.sv | 179 +++++++++++++++++
 tb/tb_seqswitch_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seqswitch_pkg.sv
// ---------------------------------------------------------------------------
// seqswitch_pkg : shared types, constants and mV helper for seqswitch_n
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seqswitch_pkg;

  typedef enum logic [1:0] {
    FWD      = 2'd0,
    REV      = 2'd1,
    PINGPONG = 2'd2,
    HOLD     = 2'd3
  } mode_t;

  localparam int C_SCHMITT_HI_MV_DEF = 2000;
  localparam int C_SCHMITT_LO_MV_DEF = 500;
  localparam int C_OUT_HI_MV_DEF     = 5000;

  // Samples carry 2 fractional bits of millivolts.
  function automatic int from_mv(input int mv);
    return mv <<< 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seqswitch_n_schmitt.sv
// ---------------------------------------------------------------------------
// schmitt_trigger : hysteresis comparator with rising-edge flag, sample gated
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module schmitt_trigger #(
  parameter int W  = 16,
  parameter int HI = 8000,
  parameter int LO = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] in,
  output logic                state,
  output logic                rise
);

  localparam logic signed [W-1:0] C_HI = W'(HI);
  localparam logic signed [W-1:0] C_LO = W'(LO);

  logic w_state_nxt;

  always_comb begin
    w_state_nxt = state;
    if (in > C_HI)
      w_state_nxt = 1'b1;
    else if (in < C_LO)
      w_state_nxt = 1'b0;
  end

  // Edge is reported on the same sample that sets the state.
  assign rise = en && !state && w_state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= 1'b0;
    else if (en)
      state <= w_state_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/seqswitch_n.sv
// ---------------------------------------------------------------------------
// seqswitch_n : N-channel CV-clocked sequential switch with direction modes
// Optional    : SEQSWITCH_N_XFADE_EN enables linear crossfade on step change
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seqswitch_n
  import seqswitch_pkg::*;
#(
  parameter int W             = 16,
  parameter int N_CH          = 4,
  parameter int SCHMITT_HI_MV = C_SCHMITT_HI_MV_DEF,
  parameter int SCHMITT_LO_MV = C_SCHMITT_LO_MV_DEF,
  parameter int OUT_HI_MV     = C_OUT_HI_MV_DEF,
  parameter int XFADE_LOG2    = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic [W-1:0]              clk_in,
  input  logic [W-1:0]              rst_in,
  input  logic [1:0]                mode,
  input  logic [$clog2(N_CH):0]     len,
  input  logic [N_CH*W-1:0]         sig_in,
  output logic [N_CH*W-1:0]         sig_out,
  output logic [W-1:0]              eoc_out,
  output logic [$clog2(N_CH)-1:0]   pos_out
);

  localparam int PW = $clog2(N_CH);
  localparam int LW = PW + 1;
  localparam logic [W-1:0] C_OUT_HI = W'(from_mv(OUT_HI_MV));

  logic                w_clk_state, w_clk_rise, w_rst_rise;
  logic [LW-1:0]       w_len;
  logic [PW-1:0]       w_last, w_pos_nxt, r_pos;
  logic                w_dir_nxt, r_dir;
  logic [W-1:0]        r_eoc;
  logic signed [W-1:0] w_in  [N_CH];
  logic signed [W-1:0] w_mix [N_CH];
  logic signed [W-1:0] r_out [N_CH];

  function automatic logic [PW-1:0] rot(input int k, input logic [PW-1:0] p);
    logic [PW:0] s;
    s = (PW+1)'(k) + {1'b0, p};
    if (s >= (PW+1)'(N_CH))
      s = s - (PW+1)'(N_CH);
    return s[PW-1:0];
  endfunction

  schmitt_trigger #(.W(W), .HI(from_mv(SCHMITT_HI_MV)), .LO(from_mv(SCHMITT_LO_MV))) u_clk_st (
    .clk(clk), .rst_n(rst_n), .en(sample_en), .in(clk_in),
    .state(w_clk_state), .rise(w_clk_rise)
  );

  schmitt_trigger #(.W(W), .HI(from_mv(SCHMITT_HI_MV)), .LO(from_mv(SCHMITT_LO_MV))) u_rst_st (
    .clk(clk), .rst_n(rst_n), .en(sample_en), .in(rst_in),
    .state(), .rise(w_rst_rise)
  );

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_in[k]            = sig_in[k*W +: W];
    assign sig_out[k*W +: W]  = r_out[k];
  end

  always_comb begin
    w_len = len;
    if (len == '0 || len > LW'(N_CH))
      w_len = LW'(N_CH);
  end

  assign w_last = PW'(w_len - LW'(1));

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (w_rst_rise) begin
      w_pos_nxt = '0;
      w_dir_nxt = 1'b0;
    end else if ({1'b0, r_pos} >= w_len) begin
      w_pos_nxt = '0;
    end else if (w_clk_rise) begin
      case (mode_t'(mode))
        FWD: w_pos_nxt = (r_pos == w_last) ? '0 : r_pos + 1'b1;
        REV: w_pos_nxt = (r_pos == '0) ? w_last : r_pos - 1'b1;
        PINGPONG: begin
          if (w_len == LW'(1)) begin
            w_pos_nxt = '0;
          end else if (!r_dir) begin
            if (r_pos == w_last) begin
              w_pos_nxt = r_pos - 1'b1;
              w_dir_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == '0) begin
              w_pos_nxt = PW'(1);
              w_dir_nxt = 1'b0;
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQSWITCH_N_XFADE_EN
  localparam int PRW = W + XFADE_LOG2 + 2;
  localparam logic [XFADE_LOG2:0] C_CNT_MAX = (XFADE_LOG2+1)'(1 << XFADE_LOG2);

  logic [PW-1:0]          r_old, r_tgt, w_old;
  logic [XFADE_LOG2:0]    r_cnt, w_cnt;
  logic                   w_chg;
  logic signed [W-1:0]    w_a [N_CH];
  logic signed [W-1:0]    w_b [N_CH];
  logic signed [W:0]      w_diff [N_CH];
  logic signed [PRW-1:0]  w_prod [N_CH];
  logic signed [PRW-1:0]  w_shft [N_CH];

  // A routed-position change (one sample late) restarts the fade from the prior target.
  assign w_chg = (r_pos != r_tgt);
  assign w_old = w_chg ? r_tgt : r_old;
  assign w_cnt = w_chg ? '0 : r_cnt;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_a[k]    = w_in[rot(k, w_old)];
      w_b[k]    = w_in[rot(k, r_pos)];
      w_diff[k] = {w_b[k][W-1], w_b[k]} - {w_a[k][W-1], w_a[k]};
      w_prod[k] = PRW'(w_diff[k]) * PRW'($signed({1'b0, w_cnt}));
      w_shft[k] = w_prod[k] >>> XFADE_LOG2;
      w_mix[k]  = w_a[k] + w_shft[k][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_old <= '0;
      r_tgt <= '0;
      r_cnt <= '0;
    end else if (sample_en) begin
      r_old <= w_old;
      r_tgt <= r_pos;
      r_cnt <= (w_cnt == C_CNT_MAX) ? w_cnt : w_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    for (int k = 0; k < N_CH; k++)
      w_mix[k] = w_in[rot(k, r_pos)];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= 1'b0;
      r_eoc <= '0;
      for (int k = 0; k < N_CH; k++)
        r_out[k] <= '0;
    end else if (sample_en) begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
      r_eoc <= (w_clk_state && r_pos == '0) ? C_OUT_HI : '0;
      for (int k = 0; k < N_CH; k++)
        r_out[k] <= w_mix[k];
    end
  end

  assign pos_out = r_pos;
  assign eoc_out = r_eoc;

endmodule

`default_nettype wire

// File: tb/tb_seqswitch_n.sv
// ---------------------------------------------------------------------------
// tb_seqswitch_n : directed self-checking bench for seqswitch_n (N_CH=4, W=16)
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seqswitch_n;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sample_en = 1'b0;
  logic [W-1:0]   clk_in = '0;
  logic [W-1:0]   rst_in = '0;
  logic [1:0]     mode = 2'd0;
  logic [2:0]     len = 3'd0;
  logic [N*W-1:0] sig_in = '0;
  logic [N*W-1:0] sig_out;
  logic [W-1:0]   eoc_out;
  logic [1:0]     pos_out;

  int total = 0;
  int bad   = 0;

  seqswitch_n #(.W(W), .N_CH(N), .XFADE_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .clk_in(clk_in), .rst_in(rst_in), .mode(mode), .len(len),
    .sig_in(sig_in), .sig_out(sig_out), .eoc_out(eoc_out), .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mv(input int x);
    return W'(x * 4);
  endfunction

  function automatic int ch(input int k);
    return int'(sig_out[k*W +: W]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input int cmv, input int rmv);
    @(negedge clk);
    clk_in    = mv(cmv);
    rst_in    = mv(rmv);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
  endtask

  task automatic edge_chk(input string tag, input int exp_pos);
    smp(8000, 0);
    chk(tag, int'(pos_out), exp_pos);
    smp(0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", int'(pos_out), 0);
    chk("rst_sig", int'(sig_out), 0);
    chk("rst_eoc", int'(eoc_out), 0);
    rst_n = 1'b1;

`ifdef SEQSWITCH_N_XFADE_EN
    sig_in = {16'd0, 16'd0, 16'd4000, 16'd0};
    smp(8000, 0);
    chk("xf_edge", ch(0), 0);
    chk("xf_pos", int'(pos_out), 1);
    smp(0, 0); chk("xf_s0", ch(0), 0);
    smp(0, 0); chk("xf_s1", ch(0), 1000);
    smp(0, 0); chk("xf_s2", ch(0), 2000);
    smp(0, 0); chk("xf_s3", ch(0), 3000);
    smp(0, 0); chk("xf_s4", ch(0), 4000);
    smp(0, 0); chk("xf_sat", ch(0), 4000);
`else
    // forward sweep, one-sample routing latency
    sig_in = {16'd400, 16'd300, 16'd200, 16'd100};
    smp(0, 0);
    chk("id_ch0", ch(0), 100);
    chk("id_ch1", ch(1), 200);
    smp(8000, 0);
    chk("e1_pos", int'(pos_out), 1);
    chk("e1_ch0_late", ch(0), 100);
    chk("e1_eoc", int'(eoc_out), 0);
    smp(0, 0);
    chk("e1_ch0", ch(0), 200);
    chk("e1_ch3", ch(3), 100);
    @(negedge clk);
    clk_in = mv(8000);
    @(posedge clk); #1;
    chk("hold_pos", int'(pos_out), 1);
    smp(0, 0);
    smp(8000, 0);
    chk("e2_pos", int'(pos_out), 2);
    smp(0, 0);
    chk("e2_ch0", ch(0), 300);
    smp(8000, 0);
    chk("e3_pos", int'(pos_out), 3);
    smp(0, 0);
    chk("e3_ch0", ch(0), 400);
    smp(8000, 0);
    chk("wrap_pos", int'(pos_out), 0);
    smp(8000, 0);
    chk("eoc_hi", int'(eoc_out), 20000);
    chk("wrap_ch0", ch(0), 100);
    smp(0, 0);
    smp(0, 0);
    chk("eoc_lo", int'(eoc_out), 0);

    // reverse, len=3
    mode = 2'd1; len = 3'd3;
    edge_chk("rev1", 2);
    edge_chk("rev2", 1);
    edge_chk("rev3", 0);
    edge_chk("rev4", 2);

    // ping-pong, len=3, from a trigger reset
    smp(0, 8000);
    chk("trig_pos", int'(pos_out), 0);
    smp(0, 0);
    mode = 2'd2;
    edge_chk("pp1", 1);
    edge_chk("pp2", 2);
    edge_chk("pp3", 1);
    edge_chk("pp4", 0);
    edge_chk("pp5", 1);
    edge_chk("pp6", 2);

    // hysteresis: only the first crossing of the high threshold counts
    mode = 2'd0; len = 3'd0;
    smp(1500, 0);
    chk("hy_1500", int'(pos_out), 2);
    smp(2100, 0);
    chk("hy_2100", int'(pos_out), 3);
    smp(1000, 0);
    smp(2100, 0);
    chk("hy_again", int'(pos_out), 3);
    smp(0, 0);

    // trigger beats a simultaneous clock edge
    edge_chk("to0", 0);
    edge_chk("to1", 1);
    edge_chk("to2", 2);
    smp(8000, 8000);
    chk("both_pos", int'(pos_out), 0);
    smp(0, 0);

    // shrinking len past pos
    edge_chk("l1", 1);
    edge_chk("l2", 2);
    edge_chk("l3", 3);
    len = 3'd2;
    smp(0, 0);
    chk("len_pos", int'(pos_out), 0);
    chk("len_ch0", ch(0), 400);
    len = 3'd0;

    // hard reset mid-run with nonzero outputs
    edge_chk("r1", 1);
    edge_chk("r2", 2);
    edge_chk("r3", 3);
    chk("pre_ch0", ch(0), 400);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("hr_pos", int'(pos_out), 0);
    chk("hr_sig", int'(sig_out), 0);
    chk("hr_eoc", int'(eoc_out), 0);
    rst_n = 1'b1;
    smp(0, 0);
    chk("hr_ch0", ch(0), 100);
    chk("hr_ch1", ch(1), 200);
    chk("hr_ch2", ch(2), 300);
    chk("hr_ch3", ch(3), 400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
